// File: rtl/latch_write_arbiter.sv
// Round-robin arbiter that serialises writes from four requesters into one shared
// level-sensitive latch, using a SETUP/ENABLE/HOLD handshake for D setup and hold.
module latch_write_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [3:0]         Req,
    input  logic [4*WIDTH-1:0] WrData,
    output logic [WIDTH-1:0]   LatchD,
    output logic               LatchEn,
    output logic [3:0]         Grant,
    output logic [3:0]         Ack,
    output logic               Busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ENABLE = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [1:0]       last_q, last_d;
    logic [1:0]       winner_q, winner_d;
    logic [WIDTH-1:0] latch_d_q, latch_d_d;
    logic             latch_en_q, latch_en_d;
    logic [3:0]       grant_q, grant_d;
    logic [3:0]       ack_q, ack_d;
    logic [1:0]       pick;

    // Search starts just after the previous winner, so the previous winner ranks last.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] idx;
        logic       found;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign pick = rr_pick(Req, last_q);

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        winner_d   = winner_q;
        latch_d_d  = latch_d_q;
        latch_en_d = 1'b0;
        grant_d    = grant_q;
        ack_d      = 4'b0000;
        case (state_q)
            IDLE: begin
                if (|Req) begin
                    state_d   = SETUP;
                    winner_d  = pick;
                    latch_d_d = WrData[int'(pick)*WIDTH +: WIDTH];
                    grant_d   = 4'b0001 << pick;
                end
            end
            SETUP: begin
                state_d    = ENABLE;
                latch_en_d = 1'b1;
            end
            ENABLE: begin
                state_d = HOLD;
                ack_d   = grant_q;
            end
            HOLD: begin
                state_d = IDLE;
                grant_d = 4'b0000;
                last_d  = winner_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            last_q     <= 2'd3;
            winner_q   <= 2'd0;
            latch_d_q  <= '0;
            latch_en_q <= 1'b0;
            grant_q    <= 4'b0000;
            ack_q      <= 4'b0000;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            winner_q   <= winner_d;
            latch_d_q  <= latch_d_d;
            latch_en_q <= latch_en_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
        end
    end

    assign LatchD  = latch_d_q;
    assign LatchEn = latch_en_q;
    assign Grant   = grant_q;
    assign Ack     = ack_q;
    assign Busy    = (state_q != IDLE);

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Directed bench for latch_write_arbiter: reset, single write, round-robin order,
// fairness, data freeze, mid-transaction reset and idle behaviour.
module tb_latch_write_arbiter;

    localparam int WIDTH = 8;

    logic               Clock;
    logic               Reset;
    logic [3:0]         Req;
    logic [4*WIDTH-1:0] WrData;
    logic [WIDTH-1:0]   LatchD;
    logic               LatchEn;
    logic [3:0]         Grant;
    logic [3:0]         Ack;
    logic               Busy;

    int n_checks = 0;
    int n_errors = 0;

    latch_write_arbiter #(.WIDTH(WIDTH)) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .Req    (Req),
        .WrData (WrData),
        .LatchD (LatchD),
        .LatchEn(LatchEn),
        .Grant  (Grant),
        .Ack    (Ack),
        .Busy   (Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    // Starts in IDLE with Req already driven; covers the four edges of one transaction.
    // perturb drops Req and overwrites WrData right after the grant.
    task automatic run_txn(input int idx, input logic [7:0] data, input bit perturb);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        tick();
        check("setup_grant", Grant, oh);
        check("setup_d", LatchD, data);
        check("setup_en", LatchEn, 1'b0);
        check("setup_busy", Busy, 1'b1);
        check("setup_ack", Ack, 4'b0000);
        if (perturb) begin
            Req    = 4'b0000;
            WrData = '1;
        end
        tick();
        check("enable_en", LatchEn, 1'b1);
        check("enable_d", LatchD, data);
        check("enable_grant", Grant, oh);
        check("enable_ack", Ack, 4'b0000);
        tick();
        check("hold_en", LatchEn, 1'b0);
        check("hold_ack", Ack, oh);
        check("hold_d", LatchD, data);
        check("hold_grant", Grant, oh);
        tick();
        check("idle_grant", Grant, 4'b0000);
        check("idle_ack", Ack, 4'b0000);
        check("idle_busy", Busy, 1'b0);
        check("idle_en", LatchEn, 1'b0);
        check("idle_d", LatchD, data);
    endtask

    initial begin
        Reset  = 1'b1;
        Req    = 4'b0000;
        WrData = '0;
        do_reset();
        check("rst_d", LatchD, 8'h00);
        check("rst_en", LatchEn, 1'b0);
        check("rst_grant", Grant, 4'b0000);
        check("rst_ack", Ack, 4'b0000);
        check("rst_busy", Busy, 1'b0);

        // Single write from requester 0
        Req    = 4'b0001;
        WrData = 32'h0000_00A5;
        run_txn(0, 8'hA5, 1'b0);
        Req = 4'b0000;

        // Round-robin with all requesters active
        do_reset();
        Req    = 4'b1111;
        WrData = 32'h4332_2110;
        run_txn(0, 8'h10, 1'b0);
        run_txn(1, 8'h21, 1'b0);
        run_txn(2, 8'h32, 1'b0);
        run_txn(3, 8'h43, 1'b0);
        run_txn(0, 8'h10, 1'b0);

        // Fairness: after requester 2, requester 0 beats 2
        do_reset();
        Req    = 4'b0100;
        WrData = 32'h0077_0066;
        run_txn(2, 8'h77, 1'b0);
        Req = 4'b0101;
        run_txn(0, 8'h66, 1'b0);

        // Data freeze: WrData changes during SETUP
        Req    = 4'b0001;
        WrData = 32'h0000_005A;
        run_txn(0, 8'h5A, 1'b1);

        // Reset during ENABLE aborts the transaction
        Req    = 4'b0100;
        WrData = 32'h0099_2211;
        tick();
        check("abort_setup_grant", Grant, 4'b0100);
        tick();
        check("abort_enable_en", LatchEn, 1'b1);
        Reset = 1'b1;
        Req   = 4'b0011;
        tick();
        check("abort_en", LatchEn, 1'b0);
        check("abort_grant", Grant, 4'b0000);
        check("abort_ack", Ack, 4'b0000);
        check("abort_d", LatchD, 8'h00);
        check("abort_busy", Busy, 1'b0);
        tick();
        check("abort_ack2", Ack, 4'b0000);
        Reset = 1'b0;
        run_txn(0, 8'h11, 1'b0);

        // One-cycle Req pulse still completes (Last is 0, so requester 1 is next)
        Req    = 4'b0010;
        WrData = 32'h0000_3C00;
        run_txn(1, 8'h3C, 1'b1);

        // Idle: no requests, nothing happens
        Req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_quiet_en", LatchEn, 1'b0);
            check("idle_quiet_busy", Busy, 1'b0);
            check("idle_quiet_d", LatchD, 8'h3C);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/latch_write_arbiter.md
LATCH_WRITE_ARBITER -- requirements
Module: latch_write_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width of the shared latch.
REQ-002 The block SHALL have port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of Clock.
REQ-004 The block SHALL have port Req, input, 4 bits: bit i is the write request from requester i.
REQ-005 The block SHALL have port WrData, input, 4*WIDTH bits: requester i data at bits [i*WIDTH +: WIDTH].
REQ-006 The block SHALL have port LatchD, output, WIDTH bits: registered data driven to the shared level-sensitive latch D input.
REQ-007 The block SHALL have port LatchEn, output, 1 bit: registered, glitch-free enable driven to the latch Clock/enable input.
REQ-008 The block SHALL have port Grant, output, 4 bits: one-hot owner of the current transaction; all zero when idle.
REQ-009 The block SHALL have port Ack, output, 4 bits: one-cycle completion pulse for the granted requester.
REQ-010 The block SHALL have port Busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-011 The FSM SHALL have four states: IDLE, SETUP, ENABLE, HOLD.
REQ-012 In IDLE with Req != 0, the next edge SHALL select a winner, load LatchD from the winner's WrData slice, set Grant one-hot, and move to SETUP.
REQ-013 In IDLE with Req == 0, the FSM SHALL stay in IDLE, with LatchD holding its last value.
REQ-014 SETUP SHALL last exactly one cycle with LatchEn=0, so D is stable before the enable rises; the next state is ENABLE.
REQ-015 ENABLE SHALL last exactly one cycle with LatchEn=1; the next state is HOLD.
REQ-016 HOLD SHALL last exactly one cycle with LatchEn=0 and LatchD unchanged, giving D hold time after the enable falls; the next state is IDLE.
REQ-017 Ack[winner] SHALL be 1 during the HOLD cycle only; Ack bits SHALL never be high in any other state.
REQ-018 Timing SHALL be as follows: if Req is sampled in IDLE at edge k, LatchEn is high between edges k+1 and k+2, and Ack is high between edges k+2 and k+3.
REQ-019 Grant SHALL remain constant from SETUP through HOLD and return to 0 on the transition to IDLE.
REQ-020 Arbitration SHALL be round-robin using a 2-bit pointer Last; search order is Last+1, Last+2, Last+3, Last, all modulo 4.
REQ-021 Last SHALL update to the winner index on the HOLD->IDLE transition only.
REQ-022 WrData and Req changes after the grant SHALL be ignored until IDLE; a transaction always runs to completion once granted.
REQ-023 A requester still asserting Req in the first IDLE cycle after its Ack SHALL be treated as a new request; back-to-back transactions SHALL cost 4 cycles each (IDLE sample included).
REQ-024 LatchEn SHALL never be high for more than one consecutive cycle, and LatchD SHALL never change while LatchEn=1 or in the cycle before or after it.
REQ-025 Busy SHALL equal (state != IDLE).

Reset
REQ-026 With Reset=1 at an edge, the next state SHALL be IDLE, with LatchEn=0, LatchD=0, Grant=0, Ack=0, Busy=0 and Last=3, so requester 0 has first priority.
REQ-027 Reset SHALL take priority over all FSM transitions, including mid-transaction (SETUP, ENABLE or HOLD); an aborted transaction issues no Ack and does not update Last.
REQ-028 Release of Reset with Req already high SHALL start arbitration on the first edge with Reset=0.

Verification
REQ-029 Single write: after reset, Req=4'b0001, WrData[7:0]=8'hA5 -> LatchD=8'hA5 at edge 1; LatchEn=1 between edges 2 and 3; Ack=4'b0001 between edges 3 and 4; Busy=0 after edge 4.
REQ-030 Round-robin: Req=4'b1111 held, slices 8'h10/8'h21/8'h32/8'h43 -> grants 0,1,2,3,0 in order; LatchD follows 10,21,32,43,10; Acks 4 cycles apart.
REQ-031 Fairness: after a grant to requester 2, Req=4'b0101 -> requester 0 wins (search order 3,0,1,2).
REQ-032 Data freeze: WrData changed from 8'h5A to 8'hFF during SETUP -> LatchD stays 8'h5A through HOLD.
REQ-033 Reset mid-op: Reset=1 in ENABLE -> next edge LatchEn=0, Grant=0, Ack never pulses, LatchD=0; with Req=4'b0011, requester 0 is granted first after release.
REQ-034 Idle/drop: Req pulses 1 cycle high in IDLE -> full SETUP/ENABLE/HOLD sequence still completes with Ack; Req=0 throughout -> LatchEn stays 0 and Busy stays 0.
